// File: rtl/upsampling_scaler.sv
// upsampling_scaler: reads a W x H image from SRAM and writes it back scaled
// by SCALE in both directions. Horizontal expansion is nearest-neighbour or
// linear interpolation; vertical expansion re-reads each source row SCALE
// times, so no line buffer is kept.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH0 | present address of pixel (0,y)
// LOAD0  | capture p0, present address of pixel (1,y)
// LOAD1  | capture p1 (right neighbour, clamped at the edge)
// EMIT   | SCALE writes for the current source pixel
// DONE   | one-cycle done pulse
module upsampling_scaler #(
  parameter int W               = 320,
  parameter int H               = 240,
  parameter int DW              = 16,
  parameter int AW              = 18,
  parameter int SCALE           = 2,
  parameter int READ_ADDR_BASE  = 0,
  parameter int WRITE_ADDR_BASE = 115200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int LG = $clog2(SCALE);
  localparam int XW = $clog2(W);
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam int SW = DW + LG + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH0 = 3'd1;
  localparam logic [2:0] S_LOAD0  = 3'd2;
  localparam logic [2:0] S_LOAD1  = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] p0_q, p0_d, p1_q, p1_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [LG-1:0] r_q, r_d, k_q, k_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] rbase_q, rbase_d;   // READ_ADDR_BASE + y*W, kept incrementally
  logic [AW-1:0] waddr_q, waddr_d;

  logic [LG:0]   wt0, wt1;
  logic [SW-1:0] acc;
  logic [DW-1:0] interp;
  logic [AW-1:0] nx;

  // Linear interpolation weights and clamped look-ahead read column.
  always_comb begin
    wt1    = {1'b0, k_q};
    wt0    = (LG+1)'(SCALE) - wt1;
    acc    = SW'(p0_q) * SW'(wt0) + SW'(p1_q) * SW'(wt1);
    interp = DW'(acc >> LG);
    nx     = AW'(x_q) + AW'(2);
    if (nx > AW'(W - 1)) nx = AW'(W - 1);
  end

  // Next-state logic for the FSM, counters and pixel registers.
  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    k_d     = k_q;
    mode_d  = mode_q;
    rbase_d = rbase_q;
    waddr_d = waddr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          r_d     = '0;
          k_d     = '0;
          mode_d  = mode;
          rbase_d = AW'(READ_ADDR_BASE);
          waddr_d = AW'(WRITE_ADDR_BASE);
          state_d = S_FETCH0;
        end
      end
      S_FETCH0: state_d = S_LOAD0;
      S_LOAD0: begin
        p0_d    = rdata;
        state_d = S_LOAD1;
      end
      S_LOAD1: begin
        p1_d    = rdata;
        k_d     = '0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        waddr_d = waddr_q + AW'(1);
        k_d     = k_q + LG'(1);
        if (k_q == LG'(SCALE - 1)) begin
          if (x_q != XW'(W - 1)) begin
            p0_d    = p1_q;
            x_d     = x_q + XW'(1);
            state_d = S_LOAD1;
          end else begin
            x_d = '0;
            if (r_q != LG'(SCALE - 1)) begin
              r_d     = r_q + LG'(1);
              state_d = S_FETCH0;
            end else begin
              r_d = '0;
              if (y_q != YW'(H - 1)) begin
                y_d     = y_q + YW'(1);
                rbase_d = rbase_q + AW'(W);
                state_d = S_FETCH0;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      p0_q    <= '0;
      p1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      mode_q  <= 1'b0;
      rbase_q <= AW'(READ_ADDR_BASE);
      waddr_q <= AW'(WRITE_ADDR_BASE);
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      rbase_q <= rbase_d;
      waddr_q <= waddr_d;
    end
  end

  // Outputs decoded from the registered state; wdata is forced to 0 off-write.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    wr_enable = (state_q == S_EMIT);
    waddr     = waddr_q;
    wdata     = '0;
    if (state_q == S_EMIT) wdata = mode_q ? interp : p0_q;
    case (state_q)
      S_LOAD0: raddr = rbase_q + AW'(1);
      S_EMIT:  raddr = rbase_q + nx;
      default: raddr = rbase_q;
    endcase
  end

endmodule

// File: tb/tb_upsampling_scaler.sv
// Directed bench for upsampling_scaler: two instances (SCALE=2 and SCALE=4)
// with registered SRAM read models and hand-computed expected write streams.
module tb_upsampling_scaler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, mode_a, busy_a, done_a, wr_enable_a;
  logic [17:0] raddr_a, waddr_a;
  logic [15:0] rdata_a, wdata_a;
  logic        start_b, mode_b, busy_b, done_b, wr_enable_b;
  logic [17:0] raddr_b, waddr_b;
  logic [15:0] rdata_b, wdata_b;

  logic [15:0] mem_a [8];
  logic [15:0] mem_b [4];

  int n_chk = 0;
  int n_err = 0;

  upsampling_scaler #(.W(4), .H(2), .DW(16), .AW(18), .SCALE(2),
                      .READ_ADDR_BASE(0), .WRITE_ADDR_BASE(115200)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .raddr(raddr_a), .rdata(rdata_a),
    .waddr(waddr_a), .wdata(wdata_a), .wr_enable(wr_enable_a));

  upsampling_scaler #(.W(4), .H(1), .DW(16), .AW(18), .SCALE(4),
                      .READ_ADDR_BASE(16), .WRITE_ADDR_BASE(256)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
    .busy(busy_b), .done(done_b), .raddr(raddr_b), .rdata(rdata_b),
    .waddr(waddr_b), .wdata(wdata_b), .wr_enable(wr_enable_b));

  // SRAM read models: data valid the cycle after the address.
  always @(posedge clk) rdata_a <= (raddr_a < 18'd8) ? mem_a[raddr_a[2:0]] : 16'hDEAD;
  always @(posedge clk)
    rdata_b <= (raddr_b >= 18'd16 && raddr_b < 18'd20) ? mem_b[raddr_b[1:0]] : 16'hDEAD;

  logic [15:0] near_r0 [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
  logic [15:0] near_r1 [8] = '{5, 5, 6, 6, 7, 7, 8, 8};
  logic [15:0] lin_r0  [8] = '{16'hFFFF, 16'h7FFF, 0, 0, 0, 0, 0, 0};
  logic [15:0] lin_r1  [8] = '{100, 150, 200, 250, 300, 350, 400, 400};
  logic [15:0] lin_b   [16] = '{10, 12, 15, 17, 20, 22, 25, 27,
                                30, 32, 35, 37, 40, 40, 40, 40};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Destination rows 0,1 come from source row 0; rows 2,3 from source row 1.
  function automatic logic [15:0] exp_a(input int sel, input int i);
    if (sel == 0) return (i / 16 == 0) ? near_r0[i % 8] : near_r1[i % 8];
    return (i / 16 == 0) ? lin_r0[i % 8] : lin_r1[i % 8];
  endfunction

  task automatic run_a(input logic m, input int sel, input bit poke);
    int nw, last_wr, done_cnt, done_cyc;
    nw = 0; last_wr = -1; done_cnt = 0; done_cyc = -1;
    @(negedge clk); start_a = 1'b1; mode_a = m;
    @(negedge clk); start_a = 1'b0;
    check("a_busy_fetch0", {31'd0, busy_a}, 32'd1);
    check("a_first_raddr", {14'd0, raddr_a}, 32'd0);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (wr_enable_a) begin
        if (nw == 0) check("a_first_wr_cycle", cyc, 3);
        if (nw < 32) begin
          check("a_wdata", {16'd0, wdata_a}, {16'd0, exp_a(sel, nw)});
          check("a_waddr", {14'd0, waddr_a}, 115200 + nw);
        end
        nw++;
        last_wr = cyc;
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (poke && cyc == 20) begin start_a = 1'b1; mode_a = ~m; end
      if (poke && cyc == 21) start_a = 1'b0;
      @(negedge clk);
    end
    check("a_write_count", nw, 32);
    check("a_last_wr_cycle", last_wr, 55);
    check("a_done_cycle", done_cyc, 56);
    check("a_done_count", done_cnt, 1);
    check("a_idle_after", {31'd0, busy_a}, 32'd0);
    mode_a = m;
  endtask

  task automatic run_b();
    int nw, last_wr, done_cnt, done_cyc;
    nw = 0; last_wr = -1; done_cnt = 0; done_cyc = -1;
    @(negedge clk); start_b = 1'b1; mode_b = 1'b1;
    @(negedge clk); start_b = 1'b0; mode_b = 1'b0;
    check("b_first_raddr", {14'd0, raddr_b}, 32'd16);
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (wr_enable_b) begin
        if (nw == 0) check("b_first_wr_cycle", cyc, 3);
        if (nw < 64) begin
          check("b_wdata", {16'd0, wdata_b}, {16'd0, lin_b[nw % 16]});
          check("b_waddr", {14'd0, waddr_b}, 256 + nw);
        end
        nw++;
        last_wr = cyc;
      end
      if (done_b) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(negedge clk);
    end
    check("b_write_count", nw, 64);
    check("b_last_wr_cycle", last_wr, 87);
    check("b_done_cycle", done_cyc, 88);
    check("b_done_count", done_cnt, 1);
  endtask

  task automatic reset_abort();
    int dcnt, wcnt;
    dcnt = 0; wcnt = 0;
    @(negedge clk); start_a = 1'b1; mode_a = 1'b0;
    @(negedge clk); start_a = 1'b0;
    repeat (10) @(negedge clk);
    check("a_pre_reset_emit", {31'd0, wr_enable_a}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_wr_enable", {31'd0, wr_enable_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_waddr", {14'd0, waddr_a}, 32'd115200);
    check("rst_raddr", {14'd0, raddr_a}, 32'd0);
    check("rst_wdata", {16'd0, wdata_a}, 32'd0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (done_a) dcnt++;
      if (wr_enable_a) wcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    check("abort_no_writes", wcnt, 0);
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; mode_a = 1'b0;
    start_b = 1'b0; mode_b = 1'b0;
    mem_a = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    mem_b = '{16'd10, 16'd20, 16'd30, 16'd40};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_wr_enable", {31'd0, wr_enable_a}, 32'd0);
    check("reset_raddr", {14'd0, raddr_a}, 32'd0);
    check("reset_waddr", {14'd0, waddr_a}, 32'd115200);
    check("reset_wdata", {16'd0, wdata_a}, 32'd0);
    check("reset_raddr_b", {14'd0, raddr_b}, 32'd16);
    check("reset_waddr_b", {14'd0, waddr_b}, 32'd256);
    reset = 1'b0;

    run_a(1'b0, 0, 1'b0);

    mem_a = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
              16'd100, 16'd200, 16'd300, 16'd400};
    run_a(1'b1, 1, 1'b0);
    run_a(1'b1, 1, 1'b1);

    mem_a = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    reset_abort();
    run_a(1'b0, 0, 1'b0);

    run_b();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
